snitch_cluster_stub: RTL and testbench

- Synthesis/test stand-in for a Snitch cluster on the FlooNoC narrow-wide network; replaces the all-zero tie-off wrapper.
- Acts as a responding AXI slave on both the narrow and wide input ports, so NoC tests complete instead of hanging.
- Output (master) ports stay idle.
- Provides response latency, response code, read-data pattern selection and per-port transaction counters.

---
 rtl/floo_narrow_wide_pkg.sv | 132 +++++++++++++
 rtl/snitch_cluster_axi_stub_slave.sv | 198 +++++++++++++++++++
 rtl/snitch_cluster_stub.sv | 81 ++++++++
 tb/tb_snitch_cluster_stub.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floo_narrow_wide_pkg.sv
// AXI channel types for the narrow and wide NoC endpoints, plus the enums used by the
// cluster stub.
package floo_narrow_wide_pkg;

    localparam int unsigned AddrWidth       = 32;
    localparam int unsigned IdWidth         = 4;
    localparam int unsigned UserWidth       = 1;
    localparam int unsigned NarrowDataWidth = 64;
    localparam int unsigned WideDataWidth   = 512;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } resp_e;

    typedef enum logic {
        DataZero = 1'b0,
        DataAddr = 1'b1
    } data_mode_e;

    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [IdWidth-1:0]   id_t;
    typedef logic [UserWidth-1:0] user_t;

    // AW and AR share one layout.
    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        user_t      user;
    } axi_ax_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [NarrowDataWidth-1:0]   data;
        logic [NarrowDataWidth/8-1:0] strb;
        logic                         last;
        user_t                        user;
    } axi_narrow_w_chan_t;

    typedef struct packed {
        id_t                        id;
        logic [NarrowDataWidth-1:0] data;
        logic [1:0]                 resp;
        logic                       last;
        user_t                      user;
    } axi_narrow_r_chan_t;

    typedef struct packed {
        logic [WideDataWidth-1:0]   data;
        logic [WideDataWidth/8-1:0] strb;
        logic                       last;
        user_t                      user;
    } axi_wide_w_chan_t;

    typedef struct packed {
        id_t                      id;
        logic [WideDataWidth-1:0] data;
        logic [1:0]               resp;
        logic                     last;
        user_t                    user;
    } axi_wide_r_chan_t;

    typedef struct packed {
        axi_ax_chan_t       aw;
        logic               aw_valid;
        axi_narrow_w_chan_t w;
        logic               w_valid;
        logic               b_ready;
        axi_ax_chan_t       ar;
        logic               ar_valid;
        logic               r_ready;
    } axi_narrow_in_req_t;

    typedef struct packed {
        logic               aw_ready;
        logic               ar_ready;
        logic               w_ready;
        logic               b_valid;
        axi_b_chan_t        b;
        logic               r_valid;
        axi_narrow_r_chan_t r;
    } axi_narrow_in_rsp_t;

    typedef struct packed {
        axi_ax_chan_t     aw;
        logic             aw_valid;
        axi_wide_w_chan_t w;
        logic             w_valid;
        logic             b_ready;
        axi_ax_chan_t     ar;
        logic             ar_valid;
        logic             r_ready;
    } axi_wide_in_req_t;

    typedef struct packed {
        logic             aw_ready;
        logic             ar_ready;
        logic             w_ready;
        logic             b_valid;
        axi_b_chan_t      b;
        logic             r_valid;
        axi_wide_r_chan_t r;
    } axi_wide_in_rsp_t;

    typedef axi_narrow_in_req_t axi_narrow_out_req_t;
    typedef axi_narrow_in_rsp_t axi_narrow_out_rsp_t;
    typedef axi_wide_in_req_t   axi_wide_out_req_t;
    typedef axi_wide_in_rsp_t   axi_wide_out_rsp_t;

    function automatic addr_t beat_bytes(input logic [2:0] size);
        return addr_t'(1) << size;
    endfunction

endpackage

// File: rtl/snitch_cluster_axi_stub_slave.sv
// Responding AXI slave: one write FSM and one read FSM, each with a single outstanding
// transaction, fixed response latency and saturating completion counters.
module axi_stub_slave
    import floo_narrow_wide_pkg::*;
#(
    parameter type             req_t       = axi_narrow_in_req_t,
    parameter type             rsp_t       = axi_narrow_in_rsp_t,
    parameter int unsigned     DataWidth   = NarrowDataWidth,
    parameter int unsigned     RespLatency = 2,
    parameter resp_e           RespCode    = RespOkay,
    parameter data_mode_e      DataMode    = DataAddr,
    parameter int unsigned     CntWidth    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  req_t                req,
    output rsp_t                rsp,
    output logic [CntWidth-1:0] wr_cnt,
    output logic [CntWidth-1:0] rd_cnt,
    output logic                err
);

    // The wait state lasts RespLatency cycles, so the counter starts one below.
    localparam logic [7:0] WaitInit = (RespLatency == 0) ? 8'd0 : 8'(RespLatency - 1);

    typedef enum logic [1:0] {WIdle, WData, WWait, WResp} w_state_e;
    typedef enum logic [1:0] {RIdle, RWait, RBurst} r_state_e;

    w_state_e            w_state_q;
    id_t                 w_id_q;
    logic [7:0]          w_len_q;
    logic [8:0]          w_beats_q;
    logic [7:0]          w_wait_q;
    logic [1:0]          b_resp_q;
    logic [CntWidth-1:0] wr_cnt_q;
    logic                err_q;

    r_state_e            r_state_q;
    id_t                 r_id_q;
    addr_t               r_addr_q;
    logic [7:0]          r_len_q;
    logic [2:0]          r_size_q;
    logic [1:0]          r_burst_q;
    logic [7:0]          r_beat_q;
    logic [7:0]          r_wait_q;
    logic [CntWidth-1:0] rd_cnt_q;

    logic [DataWidth-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= WIdle;
            w_id_q    <= '0;
            w_len_q   <= '0;
            w_beats_q <= '0;
            w_wait_q  <= '0;
            b_resp_q  <= RespOkay;
            wr_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (w_state_q)
                WIdle: begin
                    if (req.aw_valid) begin
                        w_id_q    <= req.aw.id;
                        w_len_q   <= req.aw.len;
                        w_beats_q <= '0;
                        w_state_q <= WData;
                    end
                end
                WData: begin
                    if (req.w_valid) begin
                        w_beats_q <= w_beats_q + 9'd1;
                        if (req.w.last) begin
                            // Beat count mismatch against AW len is flagged and sticky.
                            if (w_beats_q != {1'b0, w_len_q}) begin
                                b_resp_q <= RespSlverr;
                                err_q    <= 1'b1;
                            end else begin
                                b_resp_q <= RespCode;
                            end
                            w_wait_q <= WaitInit;
                            if (RespLatency == 0) begin
                                w_state_q <= WResp;
                            end else begin
                                w_state_q <= WWait;
                            end
                        end
                    end
                end
                WWait: begin
                    if (w_wait_q == 8'd0) begin
                        w_state_q <= WResp;
                    end else begin
                        w_wait_q <= w_wait_q - 8'd1;
                    end
                end
                WResp: begin
                    if (req.b_ready) begin
                        if (wr_cnt_q != {CntWidth{1'b1}}) begin
                            wr_cnt_q <= wr_cnt_q + CntWidth'(1);
                        end
                        w_state_q <= WIdle;
                    end
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RIdle;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_beat_q  <= '0;
            r_wait_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            unique case (r_state_q)
                RIdle: begin
                    if (req.ar_valid) begin
                        r_id_q    <= req.ar.id;
                        r_addr_q  <= req.ar.addr;
                        r_len_q   <= req.ar.len;
                        r_size_q  <= req.ar.size;
                        r_burst_q <= req.ar.burst;
                        r_beat_q  <= '0;
                        r_wait_q  <= WaitInit;
                        if (RespLatency == 0) begin
                            r_state_q <= RBurst;
                        end else begin
                            r_state_q <= RWait;
                        end
                    end
                end
                RWait: begin
                    if (r_wait_q == 8'd0) begin
                        r_state_q <= RBurst;
                    end else begin
                        r_wait_q <= r_wait_q - 8'd1;
                    end
                end
                RBurst: begin
                    if (req.r_ready) begin
                        if (r_beat_q == r_len_q) begin
                            if (rd_cnt_q != {CntWidth{1'b1}}) begin
                                rd_cnt_q <= rd_cnt_q + CntWidth'(1);
                            end
                            r_state_q <= RIdle;
                        end else begin
                            r_beat_q <= r_beat_q + 8'd1;
                            // WRAP bursts advance like INCR.
                            if (r_burst_q != BurstFixed) begin
                                r_addr_q <= r_addr_q + beat_bytes(r_size_q);
                            end
                        end
                    end
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

    always_comb begin
        r_data = '0;
        if (DataMode == DataAddr) begin
            for (int unsigned i = 0; i < DataWidth; i++) begin
                r_data[i] = r_addr_q[i % AddrWidth];
            end
        end
    end

    always_comb begin
        rsp          = '0;
        rsp.aw_ready = (w_state_q == WIdle) && !rst;
        rsp.w_ready  = (w_state_q == WData);
        rsp.b_valid  = (w_state_q == WResp);
        rsp.b.id     = w_id_q;
        rsp.b.resp   = b_resp_q;
        rsp.ar_ready = (r_state_q == RIdle) && !rst;
        rsp.r_valid  = (r_state_q == RBurst);
        rsp.r.id     = r_id_q;
        rsp.r.data   = r_data;
        rsp.r.resp   = RespCode;
        rsp.r.last   = (r_state_q == RBurst) && (r_beat_q == r_len_q);
    end

    logic unused_req;
    assign unused_req = ^req;

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
    assign err    = err_q;

endmodule

// File: rtl/snitch_cluster_stub.sv
// Stand-in for a Snitch cluster: answers AXI traffic on the narrow and wide inbound ports
// and keeps the outbound master ports idle.
module snitch_cluster_stub
    import floo_narrow_wide_pkg::*;
#(
    parameter int unsigned NrCores     = 1,
    parameter int unsigned RespLatency = 2,
    parameter resp_e       RespCode    = RespOkay,
    parameter data_mode_e  DataMode    = DataAddr,
    parameter int unsigned CntWidth    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NrCores-1:0]  debug_req_i,
    input  logic [NrCores-1:0]  meip_i,
    input  logic [NrCores-1:0]  mtip_i,
    input  logic [NrCores-1:0]  msip_i,
    input  axi_narrow_in_req_t  narrow_in_req_i,
    output axi_narrow_in_rsp_t  narrow_in_resp_o,
    output axi_narrow_out_req_t narrow_out_req_o,
    input  axi_narrow_out_rsp_t narrow_out_resp_i,
    input  axi_wide_in_req_t    wide_in_req_i,
    output axi_wide_in_rsp_t    wide_in_resp_o,
    output axi_wide_out_req_t   wide_out_req_o,
    input  axi_wide_out_rsp_t   wide_out_resp_i,
    output logic [CntWidth-1:0] narrow_wr_cnt_o,
    output logic [CntWidth-1:0] narrow_rd_cnt_o,
    output logic [CntWidth-1:0] wide_wr_cnt_o,
    output logic [CntWidth-1:0] wide_rd_cnt_o,
    output logic [1:0]          err_o
);

    logic narrow_err;
    logic wide_err;

    axi_stub_slave #(
        .req_t       (axi_narrow_in_req_t),
        .rsp_t       (axi_narrow_in_rsp_t),
        .DataWidth   (NarrowDataWidth),
        .RespLatency (RespLatency),
        .RespCode    (RespCode),
        .DataMode    (DataMode),
        .CntWidth    (CntWidth)
    ) u_narrow (
        .clk    (clk_i),
        .rst    (rst_i),
        .req    (narrow_in_req_i),
        .rsp    (narrow_in_resp_o),
        .wr_cnt (narrow_wr_cnt_o),
        .rd_cnt (narrow_rd_cnt_o),
        .err    (narrow_err)
    );

    axi_stub_slave #(
        .req_t       (axi_wide_in_req_t),
        .rsp_t       (axi_wide_in_rsp_t),
        .DataWidth   (WideDataWidth),
        .RespLatency (RespLatency),
        .RespCode    (RespCode),
        .DataMode    (DataMode),
        .CntWidth    (CntWidth)
    ) u_wide (
        .clk    (clk_i),
        .rst    (rst_i),
        .req    (wide_in_req_i),
        .rsp    (wide_in_resp_o),
        .wr_cnt (wide_wr_cnt_o),
        .rd_cnt (wide_rd_cnt_o),
        .err    (wide_err)
    );

    assign err_o            = {wide_err, narrow_err};
    assign narrow_out_req_o = '0;
    assign wide_out_req_o   = '0;

    // Interrupt/debug lines and outbound responses exist only to match the real cluster.
    logic unused_inputs;
    assign unused_inputs = ^{debug_req_i, meip_i, mtip_i, msip_i,
                             narrow_out_resp_i, wide_out_resp_i};

endmodule

// File: tb/tb_snitch_cluster_stub.sv
// Directed self-checking bench for snitch_cluster_stub with default parameters.
module tb_snitch_cluster_stub;
    import floo_narrow_wide_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic [0:0]          debug_req, meip, mtip, msip;
    axi_narrow_in_req_t  narrow_in_req;
    axi_narrow_in_rsp_t  narrow_in_resp;
    axi_narrow_out_req_t narrow_out_req;
    axi_narrow_out_rsp_t narrow_out_resp;
    axi_wide_in_req_t    wide_in_req;
    axi_wide_in_rsp_t    wide_in_resp;
    axi_wide_out_req_t   wide_out_req;
    axi_wide_out_rsp_t   wide_out_resp;
    logic [31:0]         narrow_wr_cnt, narrow_rd_cnt, wide_wr_cnt, wide_rd_cnt;
    logic [1:0]          err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    snitch_cluster_stub dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .debug_req_i       (debug_req),
        .meip_i            (meip),
        .mtip_i            (mtip),
        .msip_i            (msip),
        .narrow_in_req_i   (narrow_in_req),
        .narrow_in_resp_o  (narrow_in_resp),
        .narrow_out_req_o  (narrow_out_req),
        .narrow_out_resp_i (narrow_out_resp),
        .wide_in_req_i     (wide_in_req),
        .wide_in_resp_o    (wide_in_resp),
        .wide_out_req_o    (wide_out_req),
        .wide_out_resp_i   (wide_out_resp),
        .narrow_wr_cnt_o   (narrow_wr_cnt),
        .narrow_rd_cnt_o   (narrow_rd_cnt),
        .wide_wr_cnt_o     (wide_wr_cnt),
        .wide_rd_cnt_o     (wide_rd_cnt),
        .err_o             (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic narrow_aw(input logic [3:0] id, input logic [7:0] len);
        narrow_in_req.aw       = '0;
        narrow_in_req.aw.id    = id;
        narrow_in_req.aw.len   = len;
        narrow_in_req.aw.size  = 3'd3;
        narrow_in_req.aw.burst = BurstIncr;
        narrow_in_req.aw_valid = 1'b1;
        for (int i = 0; i < 20 && !narrow_in_resp.aw_ready; i++) tick();
        tick();
        narrow_in_req.aw_valid = 1'b0;
    endtask

    task automatic set_narrow_ar(input logic [3:0] id, input logic [31:0] addr,
                                 input logic [7:0] len);
        narrow_in_req.ar       = '0;
        narrow_in_req.ar.id    = id;
        narrow_in_req.ar.addr  = addr;
        narrow_in_req.ar.len   = len;
        narrow_in_req.ar.size  = 3'd3;
        narrow_in_req.ar.burst = BurstIncr;
        narrow_in_req.ar_valid = 1'b1;
    endtask

    task automatic wide_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        wide_in_req.ar       = '0;
        wide_in_req.ar.id    = id;
        wide_in_req.ar.addr  = addr;
        wide_in_req.ar.len   = len;
        wide_in_req.ar.size  = size;
        wide_in_req.ar.burst = burst;
        wide_in_req.ar_valid = 1'b1;
        for (int i = 0; i < 20 && !wide_in_resp.ar_ready; i++) tick();
        tick();
        wide_in_req.ar_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        narrow_in_req = '0;
        wide_in_req = '0;
        tick();
        tick();
        tests_run++;
        if ({narrow_in_resp.aw_ready, narrow_in_resp.ar_ready, narrow_in_resp.w_ready,
             narrow_in_resp.b_valid, narrow_in_resp.r_valid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_narrow_hs: got %b expected 00000",
                     {narrow_in_resp.aw_ready, narrow_in_resp.ar_ready, narrow_in_resp.w_ready,
                      narrow_in_resp.b_valid, narrow_in_resp.r_valid});
        end
        tests_run++;
        if ({wide_in_resp.aw_ready, wide_in_resp.ar_ready, wide_in_resp.w_ready,
             wide_in_resp.b_valid, wide_in_resp.r_valid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_wide_hs: got %b expected 00000",
                     {wide_in_resp.aw_ready, wide_in_resp.ar_ready, wide_in_resp.w_ready,
                      wide_in_resp.b_valid, wide_in_resp.r_valid});
        end
        tests_run++;
        if ({narrow_wr_cnt, narrow_rd_cnt, wide_wr_cnt, wide_rd_cnt, err} !== 130'd0) begin
            tests_failed++;
            $display("FAIL reset_counters: got %h %h %h %h err %b expected all 0",
                     narrow_wr_cnt, narrow_rd_cnt, wide_wr_cnt, wide_rd_cnt, err);
        end
        rst = 1'b0;
        narrow_in_req.b_ready = 1'b1;
        narrow_in_req.r_ready = 1'b1;
        wide_in_req.b_ready = 1'b1;
        wide_in_req.r_ready = 1'b1;
        tick();
        tests_run++;
        if ({narrow_in_resp.aw_ready, narrow_in_resp.ar_ready,
             wide_in_resp.aw_ready, wide_in_resp.ar_ready} !== 4'b1111) begin
            tests_failed++;
            $display("FAIL idle_ready: got %b expected 1111",
                     {narrow_in_resp.aw_ready, narrow_in_resp.ar_ready,
                      wide_in_resp.aw_ready, wide_in_resp.ar_ready});
        end
        tests_run++;
        if (narrow_out_req !== '0 || wide_out_req !== '0) begin
            tests_failed++;
            $display("FAIL out_tieoff: got narrow %0d wide %0d bits set expected 0",
                     $countones(narrow_out_req), $countones(wide_out_req));
        end
    endtask

    task automatic test_b_latency();
        int n;
        narrow_aw(4'd3, 8'd0);
        narrow_in_req.w      = '0;
        narrow_in_req.w.last = 1'b1;
        narrow_in_req.w_valid = 1'b1;
        tests_run++;
        if (narrow_in_resp.w_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL w_ready_data: got %b expected 1", narrow_in_resp.w_ready);
        end
        tick();
        narrow_in_req.w_valid = 1'b0;
        n = 1;
        while (!narrow_in_resp.b_valid && n < 20) begin
            tick();
            n++;
        end
        tests_run++;
        if (n !== 3) begin
            tests_failed++;
            $display("FAIL b_latency: got %0d cycles expected 3", n);
        end
        tests_run++;
        if (narrow_in_resp.b.id !== 4'd3 || narrow_in_resp.b.resp !== 2'b00) begin
            tests_failed++;
            $display("FAIL b_payload: got id %0d resp %b expected id 3 resp 00",
                     narrow_in_resp.b.id, narrow_in_resp.b.resp);
        end
        tick();
        tests_run++;
        if (narrow_wr_cnt !== 32'd1 || narrow_in_resp.b_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_cnt_1: got cnt %0d b_valid %b expected 1 0",
                     narrow_wr_cnt, narrow_in_resp.b_valid);
        end
    endtask

    task automatic test_wide_read_incr();
        int beats = 0;
        int first = 0;
        logic [31:0] ea;
        wide_ar(4'd5, 32'h1000, 8'd3, 3'd3, BurstIncr);
        for (int cyc = 1; cyc < 40 && beats < 4; cyc++) begin
            if (wide_in_resp.r_valid) begin
                if (beats == 0) first = cyc;
                ea = 32'h1000 + 32'(beats * 8);
                tests_run++;
                if (wide_in_resp.r.data !== {16{ea}} || wide_in_resp.r.last !== (beats == 3) ||
                    wide_in_resp.r.id !== 4'd5 || wide_in_resp.r.resp !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL wide_beat%0d: got addr %h last %b id %0d expected %h %b 5",
                             beats, wide_in_resp.r.data[31:0], wide_in_resp.r.last,
                             wide_in_resp.r.id, ea, beats == 3);
                end
                beats++;
            end
            tick();
        end
        tests_run++;
        if (first !== 3) begin
            tests_failed++;
            $display("FAIL r_latency: got %0d cycles expected 3", first);
        end
        tests_run++;
        if (beats !== 4 || wide_rd_cnt !== 32'd1) begin
            tests_failed++;
            $display("FAIL wide_rd_cnt: got beats %0d cnt %0d expected 4 1", beats, wide_rd_cnt);
        end
    endtask

    task automatic test_read_backpressure();
        int idx = 0;
        logic stalled = 1'b0;
        axi_narrow_r_chan_t prev_r;
        logic [31:0] ea;
        set_narrow_ar(4'd6, 32'h2000, 8'd7);
        tick();
        narrow_in_req.ar_valid = 1'b0;
        prev_r = '0;
        for (int cyc = 0; cyc < 80 && idx < 8; cyc++) begin
            narrow_in_req.r_ready = (cyc % 2 == 0);
            if (narrow_in_resp.r_valid) begin
                if (stalled) begin
                    tests_run++;
                    if (narrow_in_resp.r !== prev_r) begin
                        tests_failed++;
                        $display("FAIL bp_stable%0d: got addr %h last %b expected %h %b", idx,
                                 narrow_in_resp.r.data[31:0], narrow_in_resp.r.last,
                                 prev_r.data[31:0], prev_r.last);
                    end
                end
                if (narrow_in_req.r_ready) begin
                    ea = 32'h2000 + 32'(idx * 8);
                    tests_run++;
                    if (narrow_in_resp.r.data !== {2{ea}} ||
                        narrow_in_resp.r.last !== (idx == 7)) begin
                        tests_failed++;
                        $display("FAIL bp_beat%0d: got %h last %b expected %h %b", idx,
                                 narrow_in_resp.r.data, narrow_in_resp.r.last, {2{ea}},
                                 idx == 7);
                    end
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev_r = narrow_in_resp.r;
                end
            end
            tick();
        end
        narrow_in_req.r_ready = 1'b1;
        tests_run++;
        if (idx !== 8 || narrow_in_resp.r_valid !== 1'b0 || narrow_rd_cnt !== 32'd1) begin
            tests_failed++;
            $display("FAIL bp_done: got beats %0d r_valid %b cnt %0d expected 8 0 1",
                     idx, narrow_in_resp.r_valid, narrow_rd_cnt);
        end
    endtask

    task automatic test_write_slverr();
        narrow_aw(4'd1, 8'd3);
        for (int b = 0; b < 3; b++) begin
            narrow_in_req.w.last = (b == 2);
            narrow_in_req.w_valid = 1'b1;
            tick();
        end
        narrow_in_req.w_valid = 1'b0;
        for (int i = 0; i < 20 && !narrow_in_resp.b_valid; i++) tick();
        tests_run++;
        if (narrow_in_resp.b_valid !== 1'b1 || narrow_in_resp.b.resp !== 2'b10) begin
            tests_failed++;
            $display("FAIL short_bresp: got valid %b resp %b expected 1 10",
                     narrow_in_resp.b_valid, narrow_in_resp.b.resp);
        end
        tests_run++;
        if (err !== 2'b01) begin
            tests_failed++;
            $display("FAIL err_set: got %b expected 01", err);
        end
        tick();
        narrow_aw(4'd2, 8'd1);
        for (int b = 0; b < 2; b++) begin
            narrow_in_req.w.last = (b == 1);
            narrow_in_req.w_valid = 1'b1;
            tick();
        end
        narrow_in_req.w_valid = 1'b0;
        for (int i = 0; i < 20 && !narrow_in_resp.b_valid; i++) tick();
        tests_run++;
        if (narrow_in_resp.b.resp !== 2'b00 || narrow_in_resp.b.id !== 4'd2) begin
            tests_failed++;
            $display("FAIL good_bresp: got resp %b id %0d expected 00 2",
                     narrow_in_resp.b.resp, narrow_in_resp.b.id);
        end
        tick();
        tests_run++;
        if (err !== 2'b01 || narrow_wr_cnt !== 32'd3) begin
            tests_failed++;
            $display("FAIL err_sticky: got err %b cnt %0d expected 01 3", err, narrow_wr_cnt);
        end
    endtask

    task automatic test_same_cycle_aw_ar();
        logic r_done = 1'b0;
        logic b_seen = 1'b0;
        logic held_ok = 1'b1;
        logic ar2_ok = 1'b0;
        narrow_in_req.aw       = '0;
        narrow_in_req.aw.id    = 4'd2;
        narrow_in_req.aw_valid = 1'b1;
        set_narrow_ar(4'd4, 32'h3000, 8'd1);
        tests_run++;
        if ({narrow_in_resp.aw_ready, narrow_in_resp.ar_ready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL dual_accept: got %b expected 11",
                     {narrow_in_resp.aw_ready, narrow_in_resp.ar_ready});
        end
        tick();
        narrow_in_req.aw_valid = 1'b0;
        narrow_in_req.ar.id = 4'd7;
        narrow_in_req.ar.len = 8'd0;
        narrow_in_req.w.last = 1'b1;
        narrow_in_req.w_valid = 1'b1;
        for (int cyc = 0; cyc < 30 && !(b_seen && ar2_ok); cyc++) begin
            logic drop_w;
            logic drop_ar;
            drop_w = narrow_in_req.w_valid && narrow_in_resp.w_ready;
            drop_ar = 1'b0;
            if (narrow_in_resp.b_valid && !b_seen) begin
                b_seen = 1'b1;
                tests_run++;
                if (narrow_in_resp.b.id !== 4'd2) begin
                    tests_failed++;
                    $display("FAIL dual_bid: got %0d expected 2", narrow_in_resp.b.id);
                end
            end
            if (!r_done) begin
                if (narrow_in_resp.ar_ready) held_ok = 1'b0;
                if (narrow_in_resp.r_valid && narrow_in_resp.r.last) r_done = 1'b1;
            end else if (!ar2_ok && narrow_in_resp.ar_ready) begin
                ar2_ok = 1'b1;
                drop_ar = 1'b1;
            end
            tick();
            if (drop_w) narrow_in_req.w_valid = 1'b0;
            if (drop_ar) narrow_in_req.ar_valid = 1'b0;
        end
        tests_run++;
        if ({held_ok, b_seen, r_done, ar2_ok} !== 4'b1111) begin
            tests_failed++;
            $display("FAIL dual_flow: got held %b b %b r %b ar2 %b expected all 1",
                     held_ok, b_seen, r_done, ar2_ok);
        end
        for (int i = 0; i < 20 && !narrow_in_resp.r_valid; i++) tick();
        tests_run++;
        if (narrow_in_resp.r.id !== 4'd7 || narrow_in_resp.r.last !== 1'b1) begin
            tests_failed++;
            $display("FAIL ar2_beat: got id %0d last %b expected 7 1",
                     narrow_in_resp.r.id, narrow_in_resp.r.last);
        end
        tick();
        tests_run++;
        if (narrow_wr_cnt !== 32'd4 || narrow_rd_cnt !== 32'd3) begin
            tests_failed++;
            $display("FAIL dual_cnt: got wr %0d rd %0d expected 4 3", narrow_wr_cnt, narrow_rd_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        int beats = 0;
        wide_ar(4'd8, 32'h5000, 8'd7, 3'd3, BurstIncr);
        for (int i = 0; i < 20 && !wide_in_resp.r_valid; i++) tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (wide_in_resp.r_valid !== 1'b0 || wide_in_resp.ar_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_rst_state: got r_valid %b ar_ready %b expected 0 1",
                     wide_in_resp.r_valid, wide_in_resp.ar_ready);
        end
        tests_run++;
        if ({narrow_wr_cnt, narrow_rd_cnt, wide_wr_cnt, wide_rd_cnt, err} !== 130'd0) begin
            tests_failed++;
            $display("FAIL mid_rst_cnt: got %0d %0d %0d %0d err %b expected all 0",
                     narrow_wr_cnt, narrow_rd_cnt, wide_wr_cnt, wide_rd_cnt, err);
        end
        @(negedge clk);
        wide_ar(4'd9, 32'h40, 8'd1, 3'd2, BurstFixed);
        for (int cyc = 0; cyc < 20 && beats < 2; cyc++) begin
            if (wide_in_resp.r_valid) begin
                tests_run++;
                if (wide_in_resp.r.data !== {16{32'h40}} || wide_in_resp.r.id !== 4'd9 ||
                    wide_in_resp.r.last !== (beats == 1)) begin
                    tests_failed++;
                    $display("FAIL fixed_beat%0d: got %h id %0d last %b expected 40 9 %b",
                             beats, wide_in_resp.r.data[31:0], wide_in_resp.r.id,
                             wide_in_resp.r.last, beats == 1);
                end
                beats++;
            end
            tick();
        end
        tests_run++;
        if (beats !== 2 || wide_rd_cnt !== 32'd1 || wide_in_resp.r_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fresh_read: got beats %0d cnt %0d r_valid %b expected 2 1 0",
                     beats, wide_rd_cnt, wide_in_resp.r_valid);
        end
    endtask

    initial begin
        debug_req = '0;
        meip = '0;
        mtip = '0;
        msip = '0;
        narrow_out_resp = '0;
        wide_out_resp = '0;
        rst = 1'b1;
        narrow_in_req = '0;
        wide_in_req = '0;
        test_reset();
        test_b_latency();
        test_wide_read_incr();
        test_read_backpressure();
        test_write_slverr();
        test_same_cycle_aw_ar();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
